// File: rtl/rv32i_microcode_sequencer_pkg.sv
// rv32i microcode sequencer shared definitions.
// Opcodes, ROM entry points, trap causes and FSM states.
package rv32i_microcode_sequencer_pkg;

  localparam int END_BIT = 10;

  localparam logic [4:0] FETCH_LAST = 5'h01;
  localparam logic [4:0] TRAP_ADDR  = 5'h13;
  localparam logic [4:0] LAST_ADDR  = 5'h14;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_MISC   = 7'b0001111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [4:0] E_LB     = 5'h02;
  localparam logic [4:0] E_LH     = 5'h03;
  localparam logic [4:0] E_LW     = 5'h04;
  localparam logic [4:0] E_FENCE  = 5'h06;
  localparam logic [4:0] E_OPIMM  = 5'h07;
  localparam logic [4:0] E_AUIPC  = 5'h08;
  localparam logic [4:0] E_SB     = 5'h09;
  localparam logic [4:0] E_SH     = 5'h0A;
  localparam logic [4:0] E_SW     = 5'h0B;
  localparam logic [4:0] E_OP     = 5'h0D;
  localparam logic [4:0] E_LUI    = 5'h0E;
  localparam logic [4:0] E_BRANCH = 5'h0F;
  localparam logic [4:0] E_JALR   = 5'h10;
  localparam logic [4:0] E_JAL    = 5'h11;
  localparam logic [4:0] E_MRET   = 5'h12;

  localparam logic [31:0] MRET_INSN = 32'h30200073;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_IRQ     = 2'b01,
    CAUSE_ILLEGAL = 2'b10,
    CAUSE_UCODE   = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HOLD
  } seq_state_e;

endpackage

// File: rtl/rv32i_microcode_sequencer_if.sv
// Bus bundle between the sequencer, instruction register, ROM and CSRs.
// master drives instruction/ROM/bus status, slave is the sequencer.
interface rv32i_microcode_sequencer_if;
  logic [31:0] instr_i;
  logic [31:0] microcode_i;
  logic        stall_i;
  logic        irq_i;
  logic        mie_i;
  logic [4:0]  microcode_addr_o;
  logic        ctrl_valid_o;
  logic        retire_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;
  logic        ucode_err_o;

  modport master (
    output instr_i, microcode_i, stall_i, irq_i, mie_i,
    input  microcode_addr_o, ctrl_valid_o, retire_o,
    input  trap_o, trap_cause_o, ucode_err_o
  );

  modport slave (
    input  instr_i, microcode_i, stall_i, irq_i, mie_i,
    output microcode_addr_o, ctrl_valid_o, retire_o,
    output trap_o, trap_cause_o, ucode_err_o
  );
endinterface

// File: rtl/rv32i_ucode_dispatch.sv
// Opcode to microcode entry-point decoder.
// funct3[2] is ignored so unsigned loads share the signed entries.
module rv32i_ucode_dispatch
  import rv32i_microcode_sequencer_pkg::*;
(
  input  logic [31:0] instr_i,
  output logic [4:0]  entry,
  output logic        illegal
);
  logic [6:0] opc;
  logic [1:0] f3;

  assign opc = instr_i[6:0];
  assign f3  = instr_i[13:12];

  always_comb begin
    entry   = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (opc == OPC_LOAD): begin
        unique case (f3)
          2'b00:   entry = E_LB;
          2'b01:   entry = E_LH;
          2'b10:   entry = E_LW;
          default: illegal = 1'b1;
        endcase
      end
      (opc == OPC_STORE): begin
        unique case (f3)
          2'b00:   entry = E_SB;
          2'b01:   entry = E_SH;
          2'b10:   entry = E_SW;
          default: illegal = 1'b1;
        endcase
      end
      (opc == OPC_MISC):   entry = E_FENCE;
      (opc == OPC_OPIMM):  entry = E_OPIMM;
      (opc == OPC_AUIPC):  entry = E_AUIPC;
      (opc == OPC_OP):     entry = E_OP;
      (opc == OPC_LUI):    entry = E_LUI;
      (opc == OPC_BRANCH): entry = E_BRANCH;
      (opc == OPC_JALR):   entry = E_JALR;
      (opc == OPC_JAL):    entry = E_JAL;
      (instr_i == MRET_INSN): entry = E_MRET;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/rv32i_microcode_sequencer.sv
// Microcode ROM address sequencer for the rv32i core.
// Fetch, dispatch, stall hold and trap diversion at op boundaries.
module rv32i_microcode_sequencer
  import rv32i_microcode_sequencer_pkg::*;
(
  input logic clk_i,
  input logic rst_ni,
  rv32i_microcode_sequencer_if.slave bus
);
  seq_state_e state_q, state_d;
  logic [4:0] addr_q, addr_d;
  logic       trap_q, trap_d;
  cause_e     cause_q, cause_d;
  logic       err_q, err_d;
  logic       valid, retire;

  logic [4:0] entry;
  logic       illegal;
  logic       is_end;
  logic       in_trap;
  logic       unused_ucode;

  rv32i_ucode_dispatch u_dispatch (
    .instr_i (bus.instr_i),
    .entry   (entry),
    .illegal (illegal)
  );

  assign is_end  = bus.microcode_i[END_BIT];
  assign in_trap = (addr_q >= TRAP_ADDR);
  assign unused_ucode = ^{bus.microcode_i[31:END_BIT+1],
                          bus.microcode_i[END_BIT-1:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_BOOT;
      addr_q  <= '0;
      trap_q  <= 1'b0;
      cause_q <= CAUSE_NONE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      trap_q  <= trap_d;
      cause_q <= cause_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    trap_d  = 1'b0;
    cause_d = cause_q;
    err_d   = err_q;
    valid   = 1'b0;
    retire  = 1'b0;
    unique case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN, S_HOLD: begin
        if (bus.stall_i) begin
          state_d = S_HOLD;
        end else begin
          state_d = S_RUN;
          valid   = 1'b1;
          if (addr_q == FETCH_LAST) begin
            if (illegal) begin
              addr_d  = TRAP_ADDR;
              trap_d  = 1'b1;
              cause_d = CAUSE_ILLEGAL;
            end else begin
              addr_d = entry;
            end
          end else if (is_end) begin
            // The trap sequence never retires and never re-traps.
            retire = !in_trap;
            if (bus.irq_i && bus.mie_i && !in_trap) begin
              addr_d  = TRAP_ADDR;
              trap_d  = 1'b1;
              cause_d = CAUSE_IRQ;
            end else begin
              addr_d = '0;
            end
          end else if (addr_q >= LAST_ADDR) begin
            addr_d  = '0;
            err_d   = 1'b1;
            trap_d  = 1'b1;
            cause_d = CAUSE_UCODE;
          end else begin
            addr_d = addr_q + 5'd1;
          end
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign bus.microcode_addr_o = addr_q;
  assign bus.ctrl_valid_o     = valid;
  assign bus.retire_o         = retire;
  assign bus.trap_o           = trap_q;
  assign bus.trap_cause_o     = cause_q;
  assign bus.ucode_err_o      = err_q;
endmodule

// File: doc/rv32i_microcode_sequencer.md
Name: rv32i_microcode_sequencer

Overview:
Sequencer that drives the 5-bit address of the rv32i microcode ROM. It steps through fetch words, dispatches to each opcode's microcode entry point and holds on bus stalls. At instruction boundaries it diverts to the trap sequence for interrupts or illegal instructions. It sits between the instruction register, the bus interface and the ROM, and emits retire and trap strobes to the CSR block.

Parameters:
- END_BIT, 10: index of the microcode word bit that marks the last word of an op sequence.
- FETCH_LAST, 5'h01: address of the final fetch word; completing it triggers dispatch.
- TRAP_ADDR, 5'h13: entry point of the trap/interrupt sequence.
- LAST_ADDR, 5'h14: highest populated ROM address.

Ports:
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- instr_i, in, 32: instruction register contents; valid when the address is FETCH_LAST.
- microcode_i, in, 32: ROM word for the current address (combinational).
- stall_i, in, 1: bus busy; freeze the sequencer.
- irq_i, in, 1: pending external interrupt (level).
- mie_i, in, 1: global interrupt enable.
- microcode_addr_o, out, 5: ROM address (registered).
- ctrl_valid_o, out, 1: current microcode word may act this cycle.
- retire_o, out, 1: one-cycle pulse when an op sequence completes.
- trap_o, out, 1: one-cycle pulse on entry to TRAP_ADDR.
- trap_cause_o, out, 2: 01 irq, 10 illegal, 11 ucode error; held until the next trap.
- ucode_err_o, out, 1: sticky; set when the sequencer runs past LAST_ADDR without an END word.

Behaviour:
- Reset (async, rst_ni=0): state=S_BOOT, addr=0, retire_o=0, trap_o=0, trap_cause_o=0, ucode_err_o=0, ctrl_valid_o=0.
- States:
  - S_BOOT: one cycle with addr=0 and ctrl_valid_o=0, then go to S_RUN.
  - S_RUN: normal operation.
  - S_HOLD: entered on stall_i=1 from S_RUN.
- In S_RUN, ctrl_valid_o = !stall_i.
- stall_i=1: addr and all state hold, no strobes fire, go to (or stay in) S_HOLD. On stall_i=0, return to S_RUN with the same addr; the word executes that cycle.
- Next-address priority when not stalled:
  1. addr==FETCH_LAST: next = dispatch(instr_i). Illegal opcode: next = TRAP_ADDR, trap_o=1, cause=10.
  2. microcode_i[END_BIT]=1: retire_o=1 (not for the trap sequence). If irq_i && mie_i, next = TRAP_ADDR, trap_o=1, cause=01; otherwise next = 0.
  3. addr==LAST_ADDR without END: next = 0, ucode_err_o=1, cause=11, trap_o=1.
  4. Otherwise next = addr+1.
- Dispatch on opcode = instr_i[6:0]; f3 = instr_i[13:12]; funct3[2] is ignored, so lbu/lhu map to lb/lh.
  - LOAD 0000011: f3 00→02, 01→03, 10→04, 11→illegal.
  - MISC-MEM 0001111→06. OP-IMM 0010011→07. AUIPC 0010111→08.
  - STORE 0100011: f3 00→09, 01→0A, 10→0B, 11→illegal.
  - OP 0110011→0D. LUI 0110111→0E. BRANCH 1100011→0F. JALR 1100111→10. JAL 1101111→11.
  - SYSTEM: instr_i==32'h30200073 (mret) → 12. All other encodings → illegal.
- Interrupts are sampled only at END words, never mid-sequence or mid-fetch. An END word of the trap sequence (addr 14) returns to 0 even when irq_i stays high.
- Simultaneous events: stall_i overrides everything. Illegal at FETCH_LAST is never combined with an irq check, since the FETCH_LAST word has no END bit.
- Address arithmetic is 5-bit with no wrap past LAST_ADDR; case 3 covers that boundary.
- Reset mid-sequence aborts immediately and emits no retire_o.

Decomposition:
- Shared header rv32i_microcode_defs.vh holds:
  - opcode constants;
  - entry-point addresses (LB=02 … JAL=11, MRET=12, TRAP=13);
  - trap cause codes;
  - the mret encoding.
- Sub-module rv32i_ucode_dispatch: a combinational decoder with inputs instr_i and outputs entry[4:0] and illegal. It is shared with the future disassembly/trace monitor.

Test Plan:
- Reset, then instr_i=32'h00000013 (addi), stall_i=0 → addr 0,0,1,07,0; retire_o pulses once, on the cycle addr=07.
- lw (32'h0000A083) with stall_i=1 for 3 cycles at addr 04 → addr holds 04 for 3 cycles with ctrl_valid_o=0, then 05, then 0; one retire_o.
- irq_i=1, mie_i=1 held during add (32'h002081B3) → after addr 0D, next addr=13 with trap_o=1, cause=01; then 14, then 0 (no re-trap at 14).
- Same as above with mie_i=0 → returns to 0; trap_o never asserts.
- instr_i=32'h00000000 (illegal) → after addr 01, addr=13, trap_o=1, cause=10, retire_o=0.
- instr_i=mret 32'h30200073 → addr 12, then 0. Drive rst_ni low mid-sequence at addr 05 → addr=0 asynchronously, all outputs 0.
